// File: rtl/norm_shift_32_if.sv
// Streaming interface for the normalizer: input beat (mantissa/exponent/lzc)
// and result beat, each with a valid/ready handshake.
interface norm_shift_32_if #(
  parameter int unsigned EXP_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_mant;
  logic [EXP_W-1:0] in_exp;
  logic [5:0]       in_count;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_mant;
  logic [EXP_W-1:0] out_exp;
  logic             out_zero;
  logic             out_uflow;

  modport master (
    output in_valid, in_mant, in_exp, in_count, out_ready,
    input  in_ready, out_valid, out_mant, out_exp, out_zero, out_uflow
  );

  modport slave (
    input  in_valid, in_mant, in_exp, in_count, out_ready,
    output in_ready, out_valid, out_mant, out_exp, out_zero, out_uflow
  );
endinterface

// File: rtl/norm_shift_32.sv
// Two-stage mantissa normalizer: decode shift/flags in S1, shift in S2.
// Define NORM_SUBNORM_EN for gradual underflow; default flushes underflow to zero.
module norm_shift_32 #(
  parameter int unsigned EXP_W = 8
) (
  input logic            clk,
  input logic            rst_n,
  norm_shift_32_if.slave bus
);
  localparam int unsigned MANT_W = 32;
  localparam int unsigned CNT_W  = 6;
  localparam int unsigned CMP_W  = ((EXP_W > CNT_W) ? EXP_W : CNT_W) + 1;

  logic              s1_valid_q, s1_valid_d;
  logic [MANT_W-1:0] s1_mant_q,  s1_mant_d;
  logic [EXP_W-1:0]  s1_exp_q,   s1_exp_d;
  logic [CNT_W-1:0]  s1_shift_q, s1_shift_d;
  logic              s1_zero_q,  s1_zero_d;
  logic              s1_uflow_q, s1_uflow_d;

  logic              s2_valid_q, s2_valid_d;
  logic [MANT_W-1:0] s2_mant_q,  s2_mant_d;
  logic [EXP_W-1:0]  s2_exp_q,   s2_exp_d;
  logic              s2_zero_q,  s2_zero_d;
  logic              s2_uflow_q, s2_uflow_d;

  logic              s1_adv, s2_adv;
  logic              dec_zero, dec_uflow;
  logic [MANT_W-1:0] dec_mant;
  logic [EXP_W-1:0]  dec_exp;
  logic [CNT_W-1:0]  dec_shift;

  // Classify the incoming beat and pick the shift amount / exponent.
  always_comb begin
    dec_zero  = 1'b0;
    dec_uflow = 1'b0;
    dec_mant  = bus.in_mant;
    dec_exp   = '0;
    dec_shift = '0;
    if ((bus.in_count >= CNT_W'(MANT_W)) || (bus.in_mant == '0)) begin
      dec_zero = 1'b1;
      dec_mant = '0;
    end else if (CMP_W'(bus.in_exp) > CMP_W'(bus.in_count)) begin
      dec_shift = bus.in_count;
      dec_exp   = bus.in_exp - EXP_W'(bus.in_count);
    end else begin
      dec_uflow = 1'b1;
`ifdef NORM_SUBNORM_EN
      dec_shift = (bus.in_exp == '0) ? '0 : CNT_W'(bus.in_exp - EXP_W'(1));
`else
      dec_zero  = 1'b1;
      dec_mant  = '0;
`endif
    end
  end

  // Handshake and next-state for both stages; each stage holds unless it advances.
  always_comb begin
    s2_adv = !s2_valid_q || bus.out_ready;
    s1_adv = !s1_valid_q || s2_adv;

    s1_valid_d = s1_valid_q;
    s1_mant_d  = s1_mant_q;
    s1_exp_d   = s1_exp_q;
    s1_shift_d = s1_shift_q;
    s1_zero_d  = s1_zero_q;
    s1_uflow_d = s1_uflow_q;
    s2_valid_d = s2_valid_q;
    s2_mant_d  = s2_mant_q;
    s2_exp_d   = s2_exp_q;
    s2_zero_d  = s2_zero_q;
    s2_uflow_d = s2_uflow_q;

    if (s1_adv) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_mant_d  = dec_mant;
        s1_exp_d   = dec_exp;
        s1_shift_d = dec_shift;
        s1_zero_d  = dec_zero;
        s1_uflow_d = dec_uflow;
      end
    end

    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_mant_d  = s1_mant_q << s1_shift_q;
        s2_exp_d   = s1_exp_q;
        s2_zero_d  = s1_zero_q;
        s2_uflow_d = s1_uflow_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_mant_q  <= '0;
      s1_exp_q   <= '0;
      s1_shift_q <= '0;
      s1_zero_q  <= 1'b0;
      s1_uflow_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_mant_q  <= '0;
      s2_exp_q   <= '0;
      s2_zero_q  <= 1'b0;
      s2_uflow_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_mant_q  <= s1_mant_d;
      s1_exp_q   <= s1_exp_d;
      s1_shift_q <= s1_shift_d;
      s1_zero_q  <= s1_zero_d;
      s1_uflow_q <= s1_uflow_d;
      s2_valid_q <= s2_valid_d;
      s2_mant_q  <= s2_mant_d;
      s2_exp_q   <= s2_exp_d;
      s2_zero_q  <= s2_zero_d;
      s2_uflow_q <= s2_uflow_d;
    end
  end

  // in_ready is held low while reset is asserted so it reads 0 with the other outputs.
  assign bus.in_ready  = rst_n & s1_adv;
  assign bus.out_valid = s2_valid_q;
  assign bus.out_mant  = s2_mant_q;
  assign bus.out_exp   = s2_exp_q;
  assign bus.out_zero  = s2_zero_q;
  assign bus.out_uflow = s2_uflow_q;

endmodule

// File: tb/tb_norm_shift_32.sv
// Self-checking bench for norm_shift_32: arithmetic reference model + scoreboard,
// directed boundary beats, backpressure, mid-stream reset and random streaming.
module tb_norm_shift_32;
  logic clk;
  logic rst_n;

  norm_shift_32_if #(.EXP_W(8)) bus ();

  norm_shift_32 #(.EXP_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int n_out    = 0;
  logic [41:0] sb[$];
  logic        stall_q = 1'b0;
  logic [41:0] held    = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Result packed as {mant[31:0], exp[7:0], zero, uflow}.
  function automatic logic [41:0] model(input logic [31:0] m, input logic [7:0] e,
                                        input logic [5:0] c);
    int sh;
    if (c >= 6'd32 || m == 32'd0) return {32'h0, 8'h0, 1'b1, 1'b0};
    if (int'(e) > int'(c)) return {m << c, 8'(int'(e) - int'(c)), 1'b0, 1'b0};
`ifdef NORM_SUBNORM_EN
    sh = (e == 8'd0) ? 0 : int'(e) - 1;
    return {m << sh, 8'h0, 1'b0, 1'b1};
`else
    sh = 0;
    return {32'h0 << sh, 8'h0, 1'b1, 1'b1};
`endif
  endfunction

  function automatic logic [5:0] clz(input logic [31:0] m);
    for (int i = 31; i >= 0; i--) if (m[i]) return 6'(31 - i);
    return 6'd32;
  endfunction

  function automatic logic [41:0] dut_out();
    return {bus.out_mant, bus.out_exp, bus.out_zero, bus.out_uflow};
  endfunction

  // Single compare process: scoreboard order, hold-while-stalled, accepted inputs.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        check("hold_valid", 64'(bus.out_valid), 64'd1);
        check("hold_data", 64'(dut_out()), 64'(held));
      end
      if (bus.out_valid && bus.out_ready) begin
        n_out++;
        check("sb_nonempty", 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) check("result", 64'(dut_out()), 64'(sb.pop_front()));
      end
      stall_q = bus.out_valid && !bus.out_ready;
      held    = dut_out();
      if (bus.in_valid && bus.in_ready)
        sb.push_back(model(bus.in_mant, bus.in_exp, bus.in_count));
    end
  end

  task automatic drive(input logic v, input logic [31:0] m, input logic [7:0] e,
                       input logic [5:0] c);
    bus.in_valid = v;
    bus.in_mant  = m;
    bus.in_exp   = e;
    bus.in_count = c;
  endtask

  task automatic gen(output logic [31:0] m, output logic [7:0] e, output logic [5:0] c);
    int r;
    r = int'($urandom_range(0, 9));
    m = $urandom;
    m = m >> $urandom_range(0, 31);
    if (r == 0) m = 32'd0;
    c = clz(m);
    e = 8'($urandom_range(0, 255));
    if (r < 4) e = 8'($urandom_range(0, 40));
  endtask

  // One isolated beat: checks latency and result against a literal.
  task automatic directed(input string name, input logic [31:0] m, input logic [7:0] e,
                          input logic [5:0] c, input logic [41:0] lit);
    check({name, "_model"}, 64'(model(m, e, c)), 64'(lit));
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    drive(1'b1, m, e, c);
    @(negedge clk);
    check({name, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    drive(1'b0, 32'd0, 8'd0, 6'd0);
    @(negedge clk);
    check({name, "_lat1"}, 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    check({name, "_valid"}, 64'(bus.out_valid), 64'd1);
    check({name, "_out"}, 64'(dut_out()), 64'(lit));
  endtask

  logic [31:0] m;
  logic [7:0]  e;
  logic [5:0]  c;
  int          base;
  int          k;
  int          cyc;
  logic        acc;

  initial begin
    rst_n = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b1, 32'h1234_5678, 8'd77, 6'd3);

    // Reset held 3 cycles with in_valid high.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    end
    check("rst_outputs", 64'(dut_out()), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(1'b0, 32'd0, 8'd0, 6'd0);
    @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_idle_valid", 64'(bus.out_valid), 64'd0);

    directed("normal", 32'h0000_8000, 8'd100, 6'd16, {32'h8000_0000, 8'd84, 1'b0, 1'b0});
    directed("zero", 32'h0000_0000, 8'd50, 6'd32, {32'h0, 8'd0, 1'b1, 1'b0});
    directed("edge_exp_cnt1", 32'h0001_0000, 8'd16, 6'd15, {32'h8000_0000, 8'd1, 1'b0, 1'b0});
    directed("count0", 32'hC000_0001, 8'd1, 6'd0, {32'hC000_0001, 8'd1, 1'b0, 1'b0});
`ifdef NORM_SUBNORM_EN
    directed("uflow", 32'h0001_0000, 8'd5, 6'd15, {32'h0010_0000, 8'd0, 1'b0, 1'b1});
    directed("uflow_eq", 32'h0001_0000, 8'd15, 6'd15, {32'h4000_0000, 8'd0, 1'b0, 1'b1});
    directed("uflow_e0", 32'h0000_0003, 8'd0, 6'd30, {32'h0000_0003, 8'd0, 1'b0, 1'b1});
`else
    directed("uflow", 32'h0001_0000, 8'd5, 6'd15, {32'h0, 8'd0, 1'b1, 1'b1});
    directed("uflow_eq", 32'h0001_0000, 8'd15, 6'd15, {32'h0, 8'd0, 1'b1, 1'b1});
    directed("uflow_e0", 32'h0000_0003, 8'd0, 6'd30, {32'h0, 8'd0, 1'b1, 1'b1});
`endif

    // Backpressure: 8 back-to-back beats, out_ready low on cycles 3..6.
    repeat (3) @(posedge clk);
    #1;
    base = n_out;
    k = 0;
    cyc = 0;
    while ((k < 8 || sb.size() > 0 || bus.out_valid) && cyc < 200) begin
      bus.out_ready = !(cyc >= 3 && cyc <= 6);
      if (k < 8) begin
        gen(m, e, c);
        drive(1'b1, m, e, c);
      end else begin
        drive(1'b0, 32'd0, 8'd0, 6'd0);
      end
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      if (cyc >= 3 && cyc <= 6) check("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
      @(posedge clk); #1;
      if (acc) k++;
      cyc++;
    end
    bus.out_ready = 1'b1;
    drive(1'b0, 32'd0, 8'd0, 6'd0);
    check("bp_timeout", 64'(cyc < 200), 64'd1);
    check("bp_count", 64'(n_out - base), 64'd8);

    // Mid-stream reset discards in-flight beats.
    bus.out_ready = 1'b0;
    gen(m, e, c);
    drive(1'b1, m, e, c);
    @(posedge clk); #1;
    gen(m, e, c);
    drive(1'b1, m, e, c);
    @(posedge clk); #1;
    drive(1'b0, 32'd0, 8'd0, 6'd0);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_full", 64'(bus.out_valid), 64'd1);
    @(negedge clk);
    check("midrst_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_outputs", 64'(dut_out()), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    base = n_out;
    repeat (3) @(negedge clk);
    check("midrst_no_out", 64'(n_out - base), 64'd0);

    // Throughput: 100 random beats at full rate.
    @(posedge clk); #1;
    base = n_out;
    for (int i = 0; i < 102; i++) begin
      if (i < 100) begin
        gen(m, e, c);
        drive(1'b1, m, e, c);
      end else begin
        drive(1'b0, 32'd0, 8'd0, 6'd0);
      end
      @(negedge clk);
      if (i < 100) check("tp_in_ready", 64'(bus.in_ready), 64'd1);
      check("tp_out_valid", 64'(bus.out_valid), 64'(i >= 2));
      @(posedge clk); #1;
    end
    drive(1'b0, 32'd0, 8'd0, 6'd0);
    repeat (3) @(negedge clk);
    check("tp_count", 64'(n_out - base), 64'd100);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
